// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : intr_pkg
// Brief   : Shared types, default sizes and priority encoder for the
//           interrupt capture controller.
// Revision: 1.0 - initial release
// ============================================================================
package intr_pkg;

    localparam int c_NUM_SRC   = 4;
    localparam int c_ID_W      = 3;
    localparam int c_MAX_SRC   = 8;
    localparam int c_MAX_ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intr_state_t;

    // Scans from the top down so the last hit, i.e. the lowest index, wins.
    function automatic logic [c_MAX_ID_W-1:0] prio_lowest(input logic [c_MAX_SRC-1:0] vec);
        logic [c_MAX_ID_W-1:0] idx;
        idx = '0;
        for (int i = c_MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) idx = c_MAX_ID_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intr_edge_detect.sv
`default_nettype none
// ============================================================================
// Module  : intr_edge_detect
// Brief   : Per-bit rising-edge detector with a registered previous value.
// Revision: 1.0 - initial release
// ============================================================================
module intr_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_din;
        end
    end

    assign o_rise = i_din & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/intr_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : intr_capture_ctrl
// Brief   : Captures interrupt pulses as pending bits and presents a single
//           prioritised, masked request to the CPU control unit.
// Revision: 1.0 - initial release
// ============================================================================
module intr_capture_ctrl
    import intr_pkg::*;
#(
    parameter int NUM_SRC = c_NUM_SRC,
    parameter int ID_W    = c_ID_W
) (
    input  logic               clk,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] INTR_IN,
    input  logic               MASK_WE,
    input  logic [NUM_SRC-1:0] MASK_DIN,
    input  logic               SEI,
    input  logic               CLI,
    input  logic               INT_ACK,
    input  logic               RETI,
    output logic               INT_REQ,
    output logic [ID_W-1:0]    INT_ID,
    output logic               IE_OUT,
    output logic [NUM_SRC-1:0] PENDING
);

    intr_state_t        r_state;
    intr_state_t        w_state_nxt;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic               r_ie;
    logic [ID_W-1:0]    r_int_id;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_id_onehot;
    logic [NUM_SRC-1:0] w_clr;
    logic [ID_W-1:0]    w_winner;
    logic               w_mask_hit;
    logic               w_ie_nxt;
    logic               w_ack_take;
    logic               w_latch_id;

    intr_edge_detect #(
        .WIDTH (NUM_SRC)
    ) u_edge (
        .clk    (clk),
        .rst_n  (RESET_N),
        .i_din  (INTR_IN),
        .o_rise (w_rise)
    );

    assign w_eligible  = r_pending & r_mask;
    assign w_winner    = ID_W'(prio_lowest(c_MAX_SRC'(w_eligible)));
    assign w_id_onehot = NUM_SRC'(1) << r_int_id;
    assign w_mask_hit  = |(r_mask & w_id_onehot);
    assign w_clr       = w_ack_take ? w_id_onehot : '0;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ie_nxt    = r_ie;
        w_ack_take  = 1'b0;
        w_latch_id  = 1'b0;
        if (SEI) w_ie_nxt = 1'b1;
        case (r_state)
            IDLE: begin
                if (r_ie && (|w_eligible)) begin
                    w_state_nxt = REQ;
                    w_latch_id  = 1'b1;
                end
            end
            REQ: begin
                if (INT_ACK) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = SERVICE;
                end else if (CLI || !r_ie || !w_mask_hit) begin
                    w_state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (RETI) begin
                    w_state_nxt = IDLE;
                    w_ie_nxt    = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Clearing IE has priority over every source that sets it.
        if (w_ack_take || CLI) w_ie_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pending <= '0;
            r_mask    <= '1;
            r_ie      <= 1'b0;
            r_int_id  <= '0;
        end else begin
            // A new rise on the acknowledged source survives the clear.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_ie      <= w_ie_nxt;
            if (MASK_WE)    r_mask   <= MASK_DIN;
            if (w_latch_id) r_int_id <= w_winner;
        end
    end

    assign INT_REQ = (r_state == REQ);
    assign INT_ID  = r_int_id;
    assign IE_OUT  = r_ie;
    assign PENDING = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_intr_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_intr_capture_ctrl
// Brief   : Directed, scoreboard-checked bench for intr_capture_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_intr_capture_ctrl;

    localparam int NUM_SRC = 4;
    localparam int ID_W    = 3;

    typedef struct {
        string            tag;
        logic             req;
        logic [ID_W-1:0]  id;
        logic             ie;
        logic [NUM_SRC-1:0] pend;
    } exp_t;

    logic               clk;
    logic               RESET_N;
    logic [NUM_SRC-1:0] INTR_IN;
    logic               MASK_WE;
    logic [NUM_SRC-1:0] MASK_DIN;
    logic               SEI;
    logic               CLI;
    logic               INT_ACK;
    logic               RETI;
    logic               INT_REQ;
    logic [ID_W-1:0]    INT_ID;
    logic               IE_OUT;
    logic [NUM_SRC-1:0] PENDING;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    intr_capture_ctrl #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) dut (
        .clk      (clk),
        .RESET_N  (RESET_N),
        .INTR_IN  (INTR_IN),
        .MASK_WE  (MASK_WE),
        .MASK_DIN (MASK_DIN),
        .SEI      (SEI),
        .CLI      (CLI),
        .INT_ACK  (INT_ACK),
        .RETI     (RETI),
        .INT_REQ  (INT_REQ),
        .INT_ID   (INT_ID),
        .IE_OUT   (IE_OUT),
        .PENDING  (PENDING)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic req, input logic [ID_W-1:0] id,
                        input logic ie, input logic [NUM_SRC-1:0] pend);
        exp_t e;
        e.tag = tag; e.req = req; e.id = id; e.ie = ie; e.pend = pend;
        sb_q.push_back(e);
    endtask

    // INT_ID is only compared while a request is expected.
    task automatic check();
        exp_t e;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries required >=1");
            return;
        end
        e = sb_q.pop_front();
        checks++;
        assert (INT_REQ === e.req) else begin
            errors++;
            $error("FAIL %s.req: observed %0b expected %0b", e.tag, INT_REQ, e.req);
        end
        checks++;
        assert (IE_OUT === e.ie) else begin
            errors++;
            $error("FAIL %s.ie: observed %0b expected %0b", e.tag, IE_OUT, e.ie);
        end
        checks++;
        assert (PENDING === e.pend) else begin
            errors++;
            $error("FAIL %s.pend: observed %b expected %b", e.tag, PENDING, e.pend);
        end
        if (e.req) begin
            checks++;
            assert (INT_ID === e.id) else begin
                errors++;
                $error("FAIL %s.id: observed %0d expected %0d", e.tag, INT_ID, e.id);
            end
        end
    endtask

    task automatic step(input string tag, input logic req, input logic [ID_W-1:0] id,
                        input logic ie, input logic [NUM_SRC-1:0] pend);
        push(tag, req, id, ie, pend);
        tick();
        check();
    endtask

    initial begin
        checks = 0; errors = 0;
        RESET_N = 1'b0; INTR_IN = '0; MASK_WE = 1'b0; MASK_DIN = '0;
        SEI = 1'b0; CLI = 1'b0; INT_ACK = 1'b0; RETI = 1'b0;

        // Reset values, including INT_ID
        step("reset", 1'b0, '0, 1'b0, 4'b0000);
        checks++;
        assert (INT_ID === 3'd0) else begin
            errors++;
            $error("FAIL reset.id: observed %0d expected 0", INT_ID);
        end
        RESET_N = 1'b1;
        step("post_reset", 1'b0, '0, 1'b0, 4'b0000);

        // Single pulse on source 2
        SEI = 1'b1;           step("sei", 1'b0, '0, 1'b1, 4'b0000);
        SEI = 1'b0; INTR_IN = 4'b0100;
                              step("p2_pend", 1'b0, '0, 1'b1, 4'b0100);
        INTR_IN = '0;         step("p2_req", 1'b1, 3'd2, 1'b1, 4'b0100);
        INT_ACK = 1'b1;       step("p2_ack", 1'b0, '0, 1'b0, 4'b0000);
        INT_ACK = 1'b0; RETI = 1'b1;
                              step("p2_reti", 1'b0, '0, 1'b1, 4'b0000);
        RETI = 1'b0;          step("idle_quiet", 1'b0, '0, 1'b1, 4'b0000);

        // Simultaneous sources 1 and 3: lowest index first
        INTR_IN = 4'b1010;    step("p13_pend", 1'b0, '0, 1'b1, 4'b1010);
        INTR_IN = '0;         step("p13_req1", 1'b1, 3'd1, 1'b1, 4'b1010);
        INT_ACK = 1'b1;       step("p13_ack1", 1'b0, '0, 1'b0, 4'b1000);
        INT_ACK = 1'b0; RETI = 1'b1;
                              step("p13_reti1", 1'b0, '0, 1'b1, 4'b1000);
        RETI = 1'b0;          step("p13_req3", 1'b1, 3'd3, 1'b1, 4'b1000);
        INT_ACK = 1'b1;       step("p13_ack3", 1'b0, '0, 1'b0, 4'b0000);
        INT_ACK = 1'b0; RETI = 1'b1;
                              step("p13_reti3", 1'b0, '0, 1'b1, 4'b0000);
        RETI = 1'b0;

        // Held-high pulse with IE=0, then SEI
        CLI = 1'b1;           step("cli", 1'b0, '0, 1'b0, 4'b0000);
        CLI = 1'b0; INTR_IN = 4'b0001;
                              step("held0_a", 1'b0, '0, 1'b0, 4'b0001);
                              step("held0_b", 1'b0, '0, 1'b0, 4'b0001);
        INTR_IN = '0;
        SEI = 1'b1;           step("sei_late", 1'b0, '0, 1'b1, 4'b0001);
        SEI = 1'b0;           step("sei_req0", 1'b1, 3'd0, 1'b1, 4'b0001);

        // ACK and CLI together: ACK wins; RETI then proves SERVICE was entered
        INT_ACK = 1'b1; CLI = 1'b1;
                              step("ack_cli", 1'b0, '0, 1'b0, 4'b0000);
        INT_ACK = 1'b0; CLI = 1'b0; RETI = 1'b1;
                              step("ack_cli_reti", 1'b0, '0, 1'b1, 4'b0000);
        RETI = 1'b0;

        // CLI alone in REQ keeps pending
        INTR_IN = 4'b0100;    step("cli_pend", 1'b0, '0, 1'b1, 4'b0100);
        INTR_IN = '0;         step("cli_req", 1'b1, 3'd2, 1'b1, 4'b0100);
        CLI = 1'b1;           step("cli_drop", 1'b0, '0, 1'b0, 4'b0100);
        CLI = 1'b0;           step("cli_stay", 1'b0, '0, 1'b0, 4'b0100);
        SEI = 1'b1;           step("resei", 1'b0, '0, 1'b1, 4'b0100);
        SEI = 1'b0;           step("resei_req", 1'b1, 3'd2, 1'b1, 4'b0100);

        // ACK with a fresh rise on the same source: set wins
        INT_ACK = 1'b1; INTR_IN = 4'b0100;
                              step("ack_rise", 1'b0, '0, 1'b0, 4'b0100);
        INT_ACK = 1'b0; INTR_IN = '0; RETI = 1'b1;
                              step("ack_rise_reti", 1'b0, '0, 1'b1, 4'b0100);
        RETI = 1'b0;          step("ack_rise_req", 1'b1, 3'd2, 1'b1, 4'b0100);
        INT_ACK = 1'b1;       step("ack_rise_ack", 1'b0, '0, 1'b0, 4'b0000);
        INT_ACK = 1'b0; RETI = 1'b1;
                              step("ack_rise_reti2", 1'b0, '0, 1'b1, 4'b0000);
        RETI = 1'b0;

        // Masked source 0
        MASK_WE = 1'b1; MASK_DIN = 4'b1110;
                              step("mask_wr", 1'b0, '0, 1'b1, 4'b0000);
        MASK_WE = 1'b0; INTR_IN = 4'b0001;
                              step("mask_pend", 1'b0, '0, 1'b1, 4'b0001);
        INTR_IN = '0;         step("mask_block_a", 1'b0, '0, 1'b1, 4'b0001);
                              step("mask_block_b", 1'b0, '0, 1'b1, 4'b0001);
        MASK_WE = 1'b1; MASK_DIN = 4'b1111;
                              step("unmask_wr", 1'b0, '0, 1'b1, 4'b0001);
        MASK_WE = 1'b0;       step("unmask_req", 1'b1, 3'd0, 1'b1, 4'b0001);
        INT_ACK = 1'b1;       step("mask_ack", 1'b0, '0, 1'b0, 4'b0000);
        INT_ACK = 1'b0;

        // Reset during SERVICE with pending 0101
        INTR_IN = 4'b0101;    step("svc_pend", 1'b0, '0, 1'b0, 4'b0101);
        INTR_IN = '0;
        RESET_N = 1'b0;
        push("async_rst", 1'b0, '0, 1'b0, 4'b0000);
        #1;
        check();
        checks++;
        assert (INT_ID === 3'd0) else begin
            errors++;
            $error("FAIL async_rst.id: observed %0d expected 0", INT_ID);
        end
        tick();
        RESET_N = 1'b1;
        step("rst_idle_a", 1'b0, '0, 1'b0, 4'b0000);
        step("rst_idle_b", 1'b0, '0, 1'b0, 4'b0000);
        SEI = 1'b1;           step("rst_sei", 1'b0, '0, 1'b1, 4'b0000);
        SEI = 1'b0;           step("rst_noreq", 1'b0, '0, 1'b1, 4'b0000);
        INTR_IN = 4'b1000;    step("rst_pend3", 1'b0, '0, 1'b1, 4'b1000);
        INTR_IN = '0;         step("rst_req3", 1'b1, 3'd3, 1'b1, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
